// File: rtl/sprite_move_plotter_pkg.sv
// Shared types and constants for the sprite move plotter: FSM states,
// PS/2 move key codes, move directions and default colours.
package sprite_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_CALC,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;

    localparam logic [2:0] COLOUR_FG_DEFAULT = 3'b100;
    localparam logic [2:0] COLOUR_BG_DEFAULT = 3'b000;

    function automatic logic is_move_key(input logic [7:0] code);
        return (code == KEY_UP) || (code == KEY_DOWN) ||
               (code == KEY_LEFT) || (code == KEY_RIGHT);
    endfunction

    function automatic dir_t key_to_dir(input logic [7:0] code);
        dir_t d;
        d = DIR_UP;
        case (code)
            KEY_DOWN:  d = DIR_DOWN;
            KEY_LEFT:  d = DIR_LEFT;
            KEY_RIGHT: d = DIR_RIGHT;
            default:   d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sprite_move_plotter_block_scan_counter.sv
// Raster walker over the sprite footprint, i (column) fastest.
// Wraps back to (0,0) after the last pixel so the next pass starts clean.
module block_scan_counter #(
    parameter int BLK_W = 4,
    parameter int BLK_H = 4
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iClear,
    input  logic       iInc,
    output logic [3:0] oI,
    output logic [3:0] oJ,
    output logic       oLast
);

    localparam logic [3:0] I_MAX = 4'(BLK_W - 1);
    localparam logic [3:0] J_MAX = 4'(BLK_H - 1);

    logic [3:0] i_q, i_d;
    logic [3:0] j_q, j_d;

    // Next scan position: clear wins, otherwise step in raster order.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (iClear) begin
            i_d = '0;
            j_d = '0;
        end else if (iInc) begin
            if (i_q == I_MAX) begin
                i_d = '0;
                j_d = (j_q == J_MAX) ? 4'd0 : j_q + 4'd1;
            end else begin
                i_d = i_q + 4'd1;
            end
        end
    end

    // Scan position register with synchronous active-low reset.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign oI    = i_q;
    assign oJ    = j_q;
    assign oLast = (i_q == I_MAX) && (j_q == J_MAX);

endmodule

// File: rtl/sprite_move_plotter.sv
// Moves a solid rectangular sprite across the framebuffer on PS/2 key codes:
// erase the old footprint, then draw the new one, one pixel per cycle.
// Optional build macro: SPRITE_WRAP_EN makes positions wrap around the screen
// instead of clamping at the edges.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  INIT   | after reset; kicks off the first draw at the start position
//  WAIT   | idle, accepting move keys
//  CALC   | one cycle to work out the target position
//  ERASE  | painting background over the old footprint
//  DRAW   | painting foreground over the current footprint
//  DONE   | one-cycle completion pulse
module sprite_move_plotter
    import sprite_pkg::*;
#(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         BLK_W     = 4,
    parameter int         BLK_H     = 4,
    parameter int         STEP      = 1,
    parameter int         START_X   = 10,
    parameter int         START_Y   = 10,
    parameter logic [2:0] FG_COLOUR = COLOUR_FG_DEFAULT,
    parameter logic [2:0] BG_COLOUR = COLOUR_BG_DEFAULT
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [7:0] iKey,
    input  logic       iKeyValid,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] oPosX,
    output logic [6:0] oPosY
);

    localparam logic signed [9:0] STEP_S  = 10'(STEP);
    localparam logic signed [9:0] MAX_X_S = 10'(SCREEN_W - BLK_W);
    localparam logic signed [9:0] MAX_Y_S = 10'(SCREEN_H - BLK_H);
    localparam logic [3:0]        I_MAX   = 4'(BLK_W - 1);

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [7:0] pos_x_q, pos_x_d;
    logic [6:0] pos_y_q, pos_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic       scan_clear, scan_inc, scan_last;
    logic [3:0] scan_i, scan_j;
    logic [7:0] calc_x;
    logic [6:0] calc_y;

    // Bring an out-of-range coordinate back on screen. Signed so a step
    // past zero is seen as negative rather than wrapping to a large value.
    function automatic logic signed [9:0] fit_coord(input logic signed [9:0] v,
                                                    input logic signed [9:0] vmax);
        logic signed [9:0] r;
        r = v;
`ifdef SPRITE_WRAP_EN
        if (v < 10'sd0)
            r = vmax;
        else if (v > vmax)
            r = 10'sd0;
`else
        if (v < 10'sd0)
            r = 10'sd0;
        else if (v > vmax)
            r = vmax;
`endif
        return r;
    endfunction

    block_scan_counter #(
        .BLK_W(BLK_W),
        .BLK_H(BLK_H)
    ) u_scan (
        .iClock (iClock),
        .iResetn(iResetn),
        .iClear (scan_clear),
        .iInc   (scan_inc),
        .oI     (scan_i),
        .oJ     (scan_j),
        .oLast  (scan_last)
    );

    // Target position for the latched direction.
    always_comb begin
        logic signed [9:0] sx, sy;
        sx = $signed({2'b00, pos_x_q});
        sy = $signed({3'b000, pos_y_q});
        case (dir_q)
            DIR_UP:    sy = sy - STEP_S;
            DIR_DOWN:  sy = sy + STEP_S;
            DIR_LEFT:  sx = sx - STEP_S;
            default:   sx = sx + STEP_S;
        endcase
        calc_x = 8'(fit_coord(sx, MAX_X_S));
        calc_y = 7'(fit_coord(sy, MAX_Y_S));
    end

    // Next state plus the pixel to present on the following cycle.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        scan_clear = 1'b0;
        scan_inc   = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d  = S_DRAW;
                plot_d   = 1'b1;
                x_d      = pos_x_q;
                y_d      = pos_y_q;
                colour_d = FG_COLOUR;
            end
            S_WAIT: begin
                if (iKeyValid && is_move_key(iKey)) begin
                    dir_d   = key_to_dir(iKey);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                scan_clear = 1'b1;
                if ((calc_x == pos_x_q) && (calc_y == pos_y_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_ERASE;
                    plot_d   = 1'b1;
                    x_d      = pos_x_q;
                    y_d      = pos_y_q;
                    colour_d = BG_COLOUR;
                end
            end
            S_ERASE, S_DRAW: begin
                scan_inc = 1'b1;
                if (scan_last) begin
                    if (state_q == S_ERASE) begin
                        // Direction and position are stable during ERASE,
                        // so the CALC result is still valid here.
                        state_d  = S_DRAW;
                        pos_x_d  = calc_x;
                        pos_y_d  = calc_y;
                        plot_d   = 1'b1;
                        x_d      = calc_x;
                        y_d      = calc_y;
                        colour_d = FG_COLOUR;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    plot_d = 1'b1;
                    if (scan_i == I_MAX) begin
                        x_d = pos_x_q;
                        y_d = pos_y_q + 7'(scan_j) + 7'd1;
                    end else begin
                        x_d = pos_x_q + 8'(scan_i) + 8'd1;
                    end
                end
            end
            S_DONE: begin
                scan_clear = 1'b1;
                state_d    = S_WAIT;
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d != S_WAIT);
    end

    // State, position and registered pixel outputs.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q  <= S_INIT;
            dir_q    <= DIR_UP;
            pos_x_q  <= 8'(START_X);
            pos_y_q  <= 7'(START_Y);
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= BG_COLOUR;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oDone   = done_q;
    assign oBusy   = busy_q;
    assign oPosX   = pos_x_q;
    assign oPosY   = pos_y_q;

endmodule

// File: tb/tb_sprite_move_plotter.sv
// Scoreboard bench for sprite_move_plotter: a position model pushes expected
// pixels and completion events, a negedge monitor pops and compares them.
module tb_sprite_move_plotter;

    localparam int SW = 160, SH = 120, BW = 4, BH = 4, STEP = 1;
    localparam int SX = 10, SY = 10;
    localparam int FG = 4, BG = 0;
    localparam int MOVE_LAT = 2 + 2 * BW * BH;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] key = 8'h00;
    logic       key_valid = 1'b0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oDone, oBusy;
    logic [7:0] oPosX;
    logic [6:0] oPosY;

    always #5 clk = ~clk;

    sprite_move_plotter dut (
        .iClock   (clk),
        .iResetn  (rstn),
        .iKey     (key),
        .iKeyValid(key_valid),
        .oX       (oX),
        .oY       (oY),
        .oColour  (oColour),
        .oPlot    (oPlot),
        .oDone    (oDone),
        .oBusy    (oBusy),
        .oPosX    (oPosX),
        .oPosY    (oPosY)
    );

    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    int  px, py;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every plot or done the DUT shows must match the queue head.
    ev_t m;
    always @(negedge clk) begin
        if (mon_en) begin
            if (oPlot) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    flag("unexpected_plot");
                end else begin
                    m = exp_q.pop_front();
                    check("plot_x", int'(oX), m.x);
                    check("plot_y", int'(oY), m.y);
                    check("plot_colour", int'(oColour), m.c);
                end
            end
            if (oDone) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    flag("unexpected_done");
                end else begin
                    m = exp_q.pop_front();
                    check("done_pos_x", int'(oPosX), m.x);
                    check("done_pos_y", int'(oPosY), m.y);
                end
            end
        end
    end

    function automatic int fit(input int v, input int vmax);
`ifdef SPRITE_WRAP_EN
        if (v < 0) return vmax;
        if (v > vmax) return 0;
`else
        if (v < 0) return 0;
        if (v > vmax) return vmax;
`endif
        return v;
    endfunction

    task automatic push_block(input int x, input int y, input int c);
        for (int j = 0; j < BH; j++)
            for (int i = 0; i < BW; i++)
                exp_q.push_back('{is_done: 1'b0, x: x + i, y: y + j, c: c});
    endtask

    task automatic push_done();
        exp_q.push_back('{is_done: 1'b1, x: px, y: py, c: 0});
    endtask

    // Reference: apply one key to the model position; returns whether it is a
    // move key and whether the sprite actually moves.
    task automatic model_key(input logic [7:0] k, input bit push, output bit is_move,
                             output bit changed);
        int nx, ny;
        nx = px;
        ny = py;
        is_move = 1'b1;
        case (k)
            8'h1D:   ny = py - STEP;
            8'h1B:   ny = py + STEP;
            8'h1C:   nx = px - STEP;
            8'h23:   nx = px + STEP;
            default: is_move = 1'b0;
        endcase
        changed = 1'b0;
        if (is_move) begin
            nx = fit(nx, SW - BW);
            ny = fit(ny, SH - BH);
            changed = (nx != px) || (ny != py);
            if (changed && push) begin
                push_block(px, py, BG);
                push_block(nx, ny, FG);
            end
            px = nx;
            py = ny;
            if (push) push_done();
        end
    endtask

    function automatic logic [7:0] rand_move_code();
        logic [7:0] codes[4];
        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        return codes[$urandom_range(0, 3)];
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (oBusy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (oBusy) flag("idle_timeout");
    endtask

    // noise: 0 none, 1 random strobes while busy, 2 up key strobed mid-DRAW
    task automatic send_key(input logic [7:0] k, input int noise);
        bit is_move, changed;
        int n, lat;
        wait_idle();
        model_key(k, 1'b1, is_move, changed);
        key = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        if (!is_move) begin
            repeat (3) begin
                @(posedge clk); #1;
            end
            check("ignored_key_busy", int'(oBusy), 0);
            return;
        end
        lat = changed ? MOVE_LAT : 2;
        n = 1;
        while (!oDone && n < 200) begin
            @(posedge clk); #1;
            n++;
            key_valid = 1'b0;
            if (!oDone && n < lat) begin
                if ((noise == 1 && $urandom_range(0, 7) == 0) ||
                    (noise == 2 && n == 2 + BW * BH + 3)) begin
                    key = (noise == 2) ? 8'h1D : rand_move_code();
                    key_valid = 1'b1;
                end
            end
        end
        key_valid = 1'b0;
        check("done_latency", n, lat);
        check("pos_x", int'(oPosX), px);
        check("pos_y", int'(oPosY), py);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!oDone && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!oDone) flag(name);
    endtask

    initial begin
        bit is_move, changed;
        px = SX;
        py = SY;

        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", int'(oPlot), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_busy", int'(oBusy), 1);
        check("rst_x", int'(oX), 0);
        check("rst_y", int'(oY), 0);
        check("rst_colour", int'(oColour), BG);
        check("rst_pos_x", int'(oPosX), SX);
        check("rst_pos_y", int'(oPosY), SY);

        push_block(SX, SY, FG);
        push_done();
        mon_en = 1'b1;
        rstn = 1'b1;
        wait_done("init_done_timeout");

        send_key(8'h23, 0);                 // right: erase 10..13, draw 11..14
        for (int k = 0; k < 12; k++)
            send_key(8'h1C, 0);             // left into the edge, last press blocked/wrapped
        send_key(8'h55, 0);                 // unknown code
        send_key(8'h1B, 2);                 // down with an up strobe during DRAW
        for (int k = 0; k < 8; k++)
            send_key(8'h1D, 0);             // up towards the top edge
        for (int k = 0; k < 40; k++)
            send_key(($urandom_range(0, 9) == 0) ? 8'(8'h30 + $urandom_range(0, 15))
                                                 : rand_move_code(), 1);

        // Reset at the 5th erase pixel of a real move.
        wait_idle();
        mon_en = 1'b0;
        key = (px < SW - BW) ? 8'h23 : 8'h1C;
        model_key(key, 1'b0, is_move, changed);
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("erase5_plot", int'(oPlot), 1);
        check("erase5_colour", int'(oColour), BG);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_plot", int'(oPlot), 0);
        check("abort_busy", int'(oBusy), 1);
        check("abort_pos_x", int'(oPosX), SX);
        check("abort_pos_y", int'(oPosY), SY);
        @(posedge clk); #1;
        check("abort_plot_held", int'(oPlot), 0);
        exp_q.delete();
        px = SX;
        py = SY;
        push_block(SX, SY, FG);
        push_done();
        mon_en = 1'b1;
        rstn = 1'b1;
        wait_done("redraw_done_timeout");

        send_key(8'h1B, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
